cp0_unit: RTL and testbench

Coprocessor-0 block for the five-stage MIPS pipeline. It sits at the memory stage and consumes the exception side-band carried by the execute/memory pipeline register: exception code, branch-delay flag, PC, CP0 write enable and EXL-clear. It also owns SR, Cause, EPC and PRId. It raises `Req`, which the pipeline registers use to flush themselves and redirect fetch to 0x0000_4180. It also supplies `EPCOut` for `eret`.

---
 rtl/cp0_unit.sv | 99 +++++++++
 tb/tb_cp0_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the five-stage MIPS pipeline: owns SR, Cause, EPC and PRId,
// and raises Req to flush the pipeline and redirect fetch on exceptions/interrupts.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2024_1106
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_next;

  assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
  assign Req     = int_req | exc_req;

  assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
  assign epc_next   = BDIn ? (VPC - 32'd4) : VPC;
  assign EPCOut     = epc;

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = sr_word;
      ADDR_CAUSE: CP0Out = cause_word;
      ADDR_EPC:   CP0Out = epc;
      ADDR_PRID:  CP0Out = PRID;
      default:    CP0Out = 32'd0;
    endcase
  end

  // Exception entry beats eret, which beats a plain mtc0; IP samples HWInt every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCodeIn;
        cause_bd  <= BDIn;
        epc       <= epc_next;
      end else if (EXLClr) begin
        sr_exl <= 1'b0;
        if (en && CP0Add == ADDR_SR) begin
          sr_im <= CP0In[15:10];
          sr_ie <= CP0In[0];
        end
        if (en && CP0Add == ADDR_EPC) begin
          epc <= CP0In;
        end
      end else if (en) begin
        if (CP0Add == ADDR_SR) begin
          sr_im  <= CP0In[15:10];
          sr_exl <= CP0In[1];
          sr_ie  <= CP0In[0];
        end
        if (CP0Add == ADDR_EPC) begin
          epc <= CP0In;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit; inputs change on the falling edge,
// outputs are sampled #1 later, well away from the rising edge.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PRID_VAL = 32'h2024_1106;

  cp0_unit #(.PRID(PRID_VAL)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4] = '{32'd0, 32'd0, 32'd0, 32'h2024_1106};
    reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    @(negedge clk); next_cycle();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      CP0Add = 5'(12 + i); #1;
      checks++;
      if (CP0Out !== exp_rd[i]) begin
        errors++; $display("[TB] FAIL reset_read%0d: got %h expected %h", 12 + i, CP0Out, exp_rd[i]);
      end
    end
    checks++;
    if (Req !== 1'b0 || EPCOut !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_req_epc: got Req=%b EPCOut=%h expected 0/0", Req, EPCOut);
    end
  endtask

  task automatic test_interrupt();
    @(negedge clk);
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    next_cycle();
    en = 1'b0; HWInt = 6'b000001; VPC = 32'h0000_3000; #1;
    checks++;
    if (Req !== 1'b1) begin
      errors++; $display("[TB] FAIL int_req: got %b expected 1", Req);
    end
    next_cycle();
    HWInt = 6'd0; CP0Add = 5'd12; #1;
    checks++;
    if (CP0Out !== 32'h0000_0403) begin
      errors++; $display("[TB] FAIL int_sr: got %h expected 00000403", CP0Out);
    end
    CP0Add = 5'd13; #1;
    checks++;
    if (CP0Out !== 32'h0000_0400) begin
      errors++; $display("[TB] FAIL int_cause: got %h expected 00000400", CP0Out);
    end
    checks++;
    if (EPCOut !== 32'h0000_3000) begin
      errors++; $display("[TB] FAIL int_epc: got %h expected 00003000", EPCOut);
    end
    EXLClr = 1'b1;
    next_cycle();
    EXLClr = 1'b0;
  endtask

  task automatic test_exception_bd();
    ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h0000_3010; #1;
    checks++;
    if (Req !== 1'b1) begin
      errors++; $display("[TB] FAIL exc_req: got %b expected 1", Req);
    end
    next_cycle();
    ExcCodeIn = 5'd0; BDIn = 1'b0; CP0Add = 5'd13; #1;
    checks++;
    if (CP0Out !== 32'h8000_0010) begin
      errors++; $display("[TB] FAIL exc_cause: got %h expected 80000010", CP0Out);
    end
    checks++;
    if (EPCOut !== 32'h0000_300C) begin
      errors++; $display("[TB] FAIL exc_epc_bd: got %h expected 0000300c", EPCOut);
    end
    CP0Add = 5'd12; #1;
    checks++;
    if (CP0Out !== 32'h0000_0403) begin
      errors++; $display("[TB] FAIL exc_sr: got %h expected 00000403", CP0Out);
    end
  endtask

  task automatic test_exl_mask();
    ExcCodeIn = 5'd10; HWInt = 6'b000001; #1;
    checks++;
    if (Req !== 1'b0) begin
      errors++; $display("[TB] FAIL mask_req: got %b expected 0", Req);
    end
    next_cycle();
    ExcCodeIn = 5'd0; CP0Add = 5'd13; #1;
    checks++;
    if (CP0Out !== 32'h8000_0410 || EPCOut !== 32'h0000_300C) begin
      errors++; $display("[TB] FAIL mask_regs: got cause=%h epc=%h expected 80000410/0000300c", CP0Out, EPCOut);
    end
    EXLClr = 1'b1; #1;
    checks++;
    if (Req !== 1'b0) begin
      errors++; $display("[TB] FAIL mask_req_eret: got %b expected 0", Req);
    end
    next_cycle();
    EXLClr = 1'b0; CP0Add = 5'd12; #1;
    checks++;
    if (CP0Out !== 32'h0000_0401 || Req !== 1'b1) begin
      errors++; $display("[TB] FAIL pending_int: got sr=%h Req=%b expected 00000401/1", CP0Out, Req);
    end
    next_cycle();
    CP0Add = 5'd13; #1;
    checks++;
    if (CP0Out !== 32'h0000_0400 || EPCOut !== 32'h0000_3010) begin
      errors++; $display("[TB] FAIL pending_take: got cause=%h epc=%h expected 00000400/00003010", CP0Out, EPCOut);
    end
    HWInt = 6'd0; EXLClr = 1'b1;
    next_cycle();
    EXLClr = 1'b0;
  endtask

  task automatic test_back_to_back();
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_5000;
    ExcCodeIn = 5'd12; VPC = 32'h0000_3020; BDIn = 1'b0; #1;
    checks++;
    if (Req !== 1'b1 || CP0Out !== 32'h0000_3010) begin
      errors++; $display("[TB] FAIL suppress_pre: got Req=%b rd=%h expected 1/00003010", Req, CP0Out);
    end
    next_cycle();
    en = 1'b0; ExcCodeIn = 5'd0; #1;
    checks++;
    if (EPCOut !== 32'h0000_3020 || CP0Out !== 32'h0000_3020) begin
      errors++; $display("[TB] FAIL suppress_epc: got EPCOut=%h rd=%h expected 00003020", EPCOut, CP0Out);
    end
    CP0Add = 5'd13; #1;
    checks++;
    if (CP0Out !== 32'h0000_0030) begin
      errors++; $display("[TB] FAIL suppress_cause: got %h expected 00000030", CP0Out);
    end
    EXLClr = 1'b1;
    next_cycle();
    ExcCodeIn = 5'd3; #1;
    checks++;
    if (Req !== 1'b1) begin
      errors++; $display("[TB] FAIL req_eret_req: got %b expected 1", Req);
    end
    next_cycle();
    ExcCodeIn = 5'd0; EXLClr = 1'b0; CP0Add = 5'd12; #1;
    checks++;
    if (CP0Out !== 32'h0000_0403) begin
      errors++; $display("[TB] FAIL req_wins_eret: got sr=%h expected 00000403", CP0Out);
    end
    EXLClr = 1'b1;
    next_cycle();
    EXLClr = 1'b0;
  endtask

  task automatic test_mtc0_epc();
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h1234_5678;
    next_cycle();
    en = 1'b0; #1;
    checks++;
    if (EPCOut !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL mtc0_epc: got %h expected 12345678", EPCOut);
    end
  endtask

  task automatic test_read_only();
    HWInt = 6'b100010; en = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
    next_cycle();
    en = 1'b0; #1;
    checks++;
    if (CP0Out !== 32'h0000_880C || Req !== 1'b0) begin
      errors++; $display("[TB] FAIL cause_ro: got cause=%h Req=%b expected 0000880c/0", CP0Out, Req);
    end
    en = 1'b1; CP0Add = 5'd7; CP0In = 32'hFFFF_FFFF;
    next_cycle();
    en = 1'b0; #1;
    checks++;
    if (CP0Out !== 32'd0) begin
      errors++; $display("[TB] FAIL read7: got %h expected 00000000", CP0Out);
    end
    CP0Add = 5'd12; #1;
    checks++;
    if (CP0Out !== 32'h0000_0401 || EPCOut !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL write7_side: got sr=%h epc=%h expected 00000401/12345678", CP0Out, EPCOut);
    end
  endtask

  task automatic test_reset_override();
    HWInt = 6'd0; ExcCodeIn = 5'd5; VPC = 32'h0000_4444; reset = 1'b1;
    next_cycle();
    reset = 1'b0; ExcCodeIn = 5'd0; CP0Add = 5'd12; #1;
    checks++;
    if (CP0Out !== 32'd0 || EPCOut !== 32'd0 || Req !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_override: got sr=%h epc=%h Req=%b expected 0/0/0", CP0Out, EPCOut, Req);
    end
    CP0Add = 5'd15; #1;
    checks++;
    if (CP0Out !== PRID_VAL) begin
      errors++; $display("[TB] FAIL reset_prid: got %h expected %h", CP0Out, PRID_VAL);
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_exl_mask();
    test_back_to_back();
    test_mtc0_epc();
    test_read_only();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
